// File: rtl/byte_striping_pkg.sv
// ----------------------------------------------------------------------------
// byte_striping_pkg
// Shared definitions for the byte (un)striping blocks:
//   - state_t      : unstriper FSM state encoding (IDLE / SHIFT)
//   - LANES_*      : activeLanes codes (2'b11 behaves like LANES_4)
//   - last_index() : index of the last lane emitted for a given lane code
// ----------------------------------------------------------------------------
package byte_striping_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] LANES_1 = 2'b00;
    localparam logic [1:0] LANES_2 = 2'b01;
    localparam logic [1:0] LANES_4 = 2'b10;

    // Code 2'b11 falls into the default arm so it is treated as four lanes.
    function automatic logic [1:0] last_index(input logic [1:0] lanes);
        logic [1:0] idx;
        case (lanes)
            LANES_1: idx = 2'd0;
            LANES_2: idx = 2'd1;
            LANES_4: idx = 2'd3;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/unstriping_lane_mux.sv
// ----------------------------------------------------------------------------
// unstriping_lane_mux
// Combinational 4:1 selector of one DATA_W-wide lane.
//   lane0..lane3 : candidate lanes
//   sel          : 2-bit lane index
//   lane_out     : selected lane
// ----------------------------------------------------------------------------
module unstriping_lane_mux #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] lane0,
    input  logic [DATA_W-1:0] lane1,
    input  logic [DATA_W-1:0] lane2,
    input  logic [DATA_W-1:0] lane3,
    input  logic [1:0]        sel,
    output logic [DATA_W-1:0] lane_out
);

    // Lane selection by index.
    always_comb begin
        lane_out = lane0;
        case (sel)
            2'd0:    lane_out = lane0;
            2'd1:    lane_out = lane1;
            2'd2:    lane_out = lane2;
            2'd3:    lane_out = lane3;
            default: lane_out = lane0;
        endcase
    end

endmodule

// File: rtl/byte_unstriping.sv
// ----------------------------------------------------------------------------
// byte_unstriping
// Captures a word striped across 1, 2 or 4 lanes and replays it as a byte
// stream, lane 0 first, one lane per clock. Back-to-back words stream with
// no idle gap.
//   byteUnstripingCLK  : clock, rising edge
//   byteUnstripingRST  : asynchronous active-low reset
//   stripedLane0..3    : lane inputs (lane 0 emitted first)
//   stripedVLD         : lanes carry a valid word
//   activeLanes        : 00=1 lane, 01=2 lanes, 1x=4 lanes (sampled at capture)
//   stripedRDY         : word accepted this cycle when stripedVLD is high
//   byteUnstripingOUT  : reassembled byte, held while idle
//   byteUnstripingVLD  : byteUnstripingOUT valid
//   byteUnstripingCNT  : number of captured words, wraps at 16 bits
// ----------------------------------------------------------------------------
module byte_unstriping
    import byte_striping_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              byteUnstripingCLK,
    input  logic              byteUnstripingRST,
    input  logic [DATA_W-1:0] stripedLane0,
    input  logic [DATA_W-1:0] stripedLane1,
    input  logic [DATA_W-1:0] stripedLane2,
    input  logic [DATA_W-1:0] stripedLane3,
    input  logic              stripedVLD,
    input  logic [1:0]        activeLanes,
    output logic              stripedRDY,
    output logic [DATA_W-1:0] byteUnstripingOUT,
    output logic              byteUnstripingVLD,
    output logic [15:0]       byteUnstripingCNT
);

    state_t                  state_r;
    logic [1:0]              idx_r;
    logic [3:0][DATA_W-1:0]  hold_lane_r;
    logic [1:0]              hold_lanes_r;
    logic [DATA_W-1:0]       out_r;
    logic                    vld_r;
    logic [15:0]             cnt_r;

    logic [1:0]              last_idx_s;
    logic [1:0]              next_idx_s;
    logic                    rdy_s;
    logic                    capture_s;
    logic [DATA_W-1:0]       next_byte_s;

    // Handshake: ready when idle or when the last lane of the held word is on
    // the output; forced low while reset is asserted.
    always_comb begin
        last_idx_s = last_index(hold_lanes_r);
        next_idx_s = idx_r + 2'd1;
        if (!byteUnstripingRST) begin
            rdy_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            rdy_s = 1'b1;
        end else if (idx_r == last_idx_s) begin
            rdy_s = 1'b1;
        end else begin
            rdy_s = 1'b0;
        end
        capture_s = stripedVLD & rdy_s;
    end

    unstriping_lane_mux #(
        .DATA_W (DATA_W)
    ) u_lane_mux (
        .lane0    (hold_lane_r[0]),
        .lane1    (hold_lane_r[1]),
        .lane2    (hold_lane_r[2]),
        .lane3    (hold_lane_r[3]),
        .sel      (next_idx_s),
        .lane_out (next_byte_s)
    );

    // FSM with registered byte/valid/count outputs. Lane 0 of a new word is
    // taken straight from the inputs so it appears one cycle after capture.
    always_ff @(posedge byteUnstripingCLK or negedge byteUnstripingRST) begin
        if (!byteUnstripingRST) begin
            state_r      <= ST_IDLE;
            idx_r        <= 2'd0;
            hold_lane_r  <= '0;
            hold_lanes_r <= 2'b00;
            out_r        <= '0;
            vld_r        <= 1'b0;
            cnt_r        <= 16'd0;
        end else if (capture_s) begin
            hold_lane_r  <= {stripedLane3, stripedLane2, stripedLane1, stripedLane0};
            hold_lanes_r <= activeLanes;
            state_r      <= ST_SHIFT;
            idx_r        <= 2'd0;
            out_r        <= stripedLane0;
            vld_r        <= 1'b1;
            cnt_r        <= cnt_r + 16'd1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    vld_r <= 1'b0;
                end
                ST_SHIFT: begin
                    if (idx_r == last_idx_s) begin
                        state_r <= ST_IDLE;
                        vld_r   <= 1'b0;
                    end else begin
                        idx_r   <= next_idx_s;
                        out_r   <= next_byte_s;
                        vld_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    vld_r   <= 1'b0;
                end
            endcase
        end
    end

    assign stripedRDY        = rdy_s;
    assign byteUnstripingOUT = out_r;
    assign byteUnstripingVLD = vld_r;
    assign byteUnstripingCNT = cnt_r;

endmodule
